tia_d1_phase_seq: RTL and testbench
===================================

Name: tia_d1_phase_seq

Overview:
- Two-phase, non-overlapping clock sequencer for chains of D1 cells, such as the horizontal/polynomial counters and shift registers.
- Derives the s1/s2 phase strobes that clock a D1 chain from the single system clock. Counts completed shift steps, flags wrap-around at a programmable period and supports a synchronous restart.
- Sits between the system clock domain and every D1-based shift chain. All D1 chains driven by one instance advance in lock-step.

Parameters:
- PH_W, 1: clk cycles each phase strobe (s1 or s2) is held high; legal range 1..15.
- GAP_W, 1: dead clk cycles after each strobe, during which both s1 and s2 are low; legal range 1..15. A value of 0 is illegal because it allows overlap.
- PERIOD, 57: number of shift steps per wrap; legal range 2..2^CNT_W.
- CNT_W, 6: width of the step counter.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  run request; sampled at step boundaries only.
- sync  in  1  restart request; pulse or level.
- s1  out  1  phase-1 strobe to D1 s1 inputs (transparent-latch enable).
- s2  out  1  phase-2 strobe to D1 s2 inputs (the edge that launches out).
- count  out  CNT_W  number of completed steps since the last wrap or sync.
- wrap  out  1  one-clk pulse when count returns to 0 from PERIOD-1.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: asynchronous on reset_n low.
  - Outputs: s1=0, s2=0, count=0, wrap=0, busy=0.
  - State: IDLE; sync_pend=0; phase timer=0.
  - Reset is permitted mid-step. s1/s2 drop in the same cycle, so D1 taps may be left half-updated. This is accepted; the chain owner re-syncs the chain.
- All outputs are registered; s1 and s2 come directly from flops, with no combinational decode onto the strobes.
- States: IDLE, P1, G1, P2, G2.
  - IDLE: s1=s2=0. Go to P1 when en=1.
  - P1: s1=1 for PH_W cycles, then go to G1.
  - G1: both strobes low for GAP_W cycles, then go to P2.
  - P2: s2=1 for PH_W cycles, then go to G2.
  - G2: both strobes low for GAP_W cycles, then end the step.
- One step lasts 2*(PH_W+GAP_W) clks; 4 clks at the defaults.
- Timing invariants:
  - s1 and s2 are never high in the same cycle.
  - There are at least GAP_W low cycles between a falling edge of one strobe and the rising edge of the other.
- First strobe latency: en rising while in IDLE gives s1=1 on the next posedge (1 clk).
- Step end, on the last G2 cycle:
  - Update count:
    - If sync_pend=1: count=0, wrap=0, clear sync_pend.
    - Else if count==PERIOD-1: count=0 and wrap pulses for 1 clk.
    - Else count=count+1.
  - Next state: P1 if en=1, else IDLE.
- en=0 mid-step: the step always completes through G2. A partial s1/s2 pair is never issued.
- sync:
  - sync=1 in any cycle sets sync_pend.
  - In IDLE, sync clears count immediately on the next clk and clears sync_pend. No strobes are issued.
  - sync asserted together with a would-be wrap: the sync wins, count=0 and wrap stays 0.
- count arithmetic is modulo PERIOD and never exceeds PERIOD-1.
- wrap stays 0 in every cycle except the single pulse at step end.

Test Plan:
- Reset, then hold en=1 at the defaults: s1 is high on cycle 1, s2 on cycle 3, period is 4 clk; after 4 clks count=1; s1&s2 is never 1 (property check across the whole run).
- en=1 continuous, PERIOD=57: after 228 clks count returns to 0 with exactly one wrap pulse, in the same cycle count goes 56 -> 0.
- Drop en during P1: s2 still pulses once, count increments by 1, FSM enters IDLE with busy=0; s1/s2 stay low for 10 further clks.
- Pulse sync during G1 at count=20: at step end count=0 and no wrap; the next step yields count=1.
- Assert reset_n=0 while s2=1: s2, count and busy drop to 0 asynchronously, before the next posedge; release with en=1 and the first s1 follows 1 clk later.
- PH_W=3, GAP_W=2: s1 is high for 3 clks, both strobes are low for 2, s2 is high for 3, both are low for 2; step length is 10 clks.

Source files
------------

// File: rtl/tia_d1_phase_seq.sv
`default_nettype none
// ============================================================================
// Module   : tia_d1_phase_seq
// Brief    : Two-phase non-overlapping s1/s2 strobe sequencer for D1 chains.
//            Counts completed shift steps modulo PERIOD, pulses wrap on
//            roll-over and honours a synchronous restart (sync).
// Revision : 1.0  initial release
// ============================================================================
module tia_d1_phase_seq #(
  parameter int PH_W   = 1,
  parameter int GAP_W  = 1,
  parameter int PERIOD = 57,
  parameter int CNT_W  = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             sync,
  output logic             s1,
  output logic             s2,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             busy
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P1   = 3'd1,
    ST_G1   = 3'd2,
    ST_P2   = 3'd3,
    ST_G2   = 3'd4
  } state_t;

  localparam logic [3:0]       c_ph_last  = 4'(PH_W - 1);
  localparam logic [3:0]       c_gap_last = 4'(GAP_W - 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_timer;
  logic [3:0]         w_timer_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               r_pend;
  logic               w_pend_nxt;
  logic               r_wrap;
  logic               w_wrap_nxt;
  logic               r_s1;
  logic               r_s2;
  logic               r_busy;

  // Next-state, phase timer, step counter and restart bookkeeping.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    // A sync seen in this very cycle counts as pending, so a sync that
    // coincides with a step end (or a would-be wrap) takes effect at once.
    w_pend_nxt  = r_pend | sync;
    case (r_state)
      ST_IDLE: begin
        w_timer_nxt = 4'd0;
        if (w_pend_nxt) begin
          w_count_nxt = '0;
          w_pend_nxt  = 1'b0;
        end
        if (en) begin
          w_state_nxt = ST_P1;
        end
      end
      ST_P1: begin
        if (r_timer == c_ph_last) begin
          w_timer_nxt = 4'd0;
          w_state_nxt = ST_G1;
        end else begin
          w_timer_nxt = r_timer + 4'd1;
        end
      end
      ST_G1: begin
        if (r_timer == c_gap_last) begin
          w_timer_nxt = 4'd0;
          w_state_nxt = ST_P2;
        end else begin
          w_timer_nxt = r_timer + 4'd1;
        end
      end
      ST_P2: begin
        if (r_timer == c_ph_last) begin
          w_timer_nxt = 4'd0;
          w_state_nxt = ST_G2;
        end else begin
          w_timer_nxt = r_timer + 4'd1;
        end
      end
      ST_G2: begin
        if (r_timer == c_gap_last) begin
          // Step boundary: the only place count moves and en is sampled.
          w_timer_nxt = 4'd0;
          if (w_pend_nxt) begin
            w_count_nxt = '0;
            w_pend_nxt  = 1'b0;
          end else if (r_count == c_cnt_last) begin
            w_count_nxt = '0;
            w_wrap_nxt  = 1'b1;
          end else begin
            w_count_nxt = r_count + c_cnt_one;
          end
          w_state_nxt = en ? ST_P1 : ST_IDLE;
        end else begin
          w_timer_nxt = r_timer + 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = 4'd0;
      end
    endcase
  end

  // State register; strobes and busy are decoded from the next state so
  // that every output leaves a flop with no gating in front of the pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_timer <= 4'd0;
      r_count <= '0;
      r_pend  <= 1'b0;
      r_wrap  <= 1'b0;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_count <= w_count_nxt;
      r_pend  <= w_pend_nxt;
      r_wrap  <= w_wrap_nxt;
      r_s1    <= (w_state_nxt == ST_P1);
      r_s2    <= (w_state_nxt == ST_P2);
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  assign s1    = r_s1;
  assign s2    = r_s2;
  assign count = r_count;
  assign wrap  = r_wrap;
  assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_tia_d1_phase_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_tia_d1_phase_seq
// Brief    : Self-checking bench for tia_d1_phase_seq. Two instances: the
//            default timing (1/1, PERIOD 57) and a slow one (3/2, PERIOD 5).
//            A step-position reference model predicts every output.
// Revision : 1.0  initial release
// ============================================================================
module tb_tia_d1_phase_seq;

  logic       clk;
  logic       reset_n;
  logic       en0, sync0, en1, sync1;
  logic       s1_0, s2_0, wrap_0, busy_0;
  logic [5:0] count_0;
  logic       s1_1, s2_1, wrap_1, busy_1;
  logic [2:0] count_1;

  int n_vec;
  int n_fail;

  tia_d1_phase_seq dut0 (
    .clk(clk), .reset_n(reset_n), .en(en0), .sync(sync0),
    .s1(s1_0), .s2(s2_0), .count(count_0), .wrap(wrap_0), .busy(busy_0)
  );

  tia_d1_phase_seq #(.PH_W(3), .GAP_W(2), .PERIOD(5), .CNT_W(3)) dut1 (
    .clk(clk), .reset_n(reset_n), .en(en1), .sync(sync1),
    .s1(s1_1), .s2(s2_1), .count(count_1), .wrap(wrap_1), .busy(busy_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a running flag plus position inside the step.
  typedef struct packed {
    logic running;
    int   pos;
    int   count;
    logic pend;
    logic wrap;
  } model_t;

  model_t m0, m1;

  function automatic model_t mstep(model_t m, logic e, logic sy, int ph, int gap, int period);
    model_t n;
    int     len;
    n      = m;
    len    = 2 * (ph + gap);
    n.wrap = 1'b0;
    n.pend = m.pend | sy;
    if (!m.running) begin
      if (n.pend) begin
        n.count = 0;
        n.pend  = 1'b0;
      end
      if (e) begin
        n.running = 1'b1;
        n.pos     = 0;
      end
    end else if (m.pos == len - 1) begin
      if (n.pend) begin
        n.count = 0;
        n.pend  = 1'b0;
      end else if (m.count == period - 1) begin
        n.count = 0;
        n.wrap  = 1'b1;
      end else begin
        n.count = m.count + 1;
      end
      n.running = e;
      n.pos     = 0;
    end else begin
      n.pos = m.pos + 1;
    end
    return n;
  endfunction

  // Expected {s1, s2, busy, count[5:0], wrap}.
  function automatic logic [9:0] mexp(model_t m, int ph, int gap);
    logic es1, es2;
    logic [5:0] c;
    es1 = m.running && (m.pos < ph);
    es2 = m.running && (m.pos >= ph + gap) && (m.pos < 2 * ph + gap);
    c   = 6'(m.count);
    return {es1, es2, m.running, c, m.wrap};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      m0 <= mstep(m0, en0, sync0, 1, 1, 57);
      m1 <= mstep(m1, en1, sync1, 3, 2, 5);
    end
  end

  // Strobes must never overlap on either instance.
  always @(negedge clk) begin
    if (reset_n) begin
      n_vec++;
      if ((s1_0 & s2_0) || (s1_1 & s2_1)) begin
        n_fail++;
        $display("FAIL overlap t=%0t dut0 s1/s2=%b%b dut1 s1/s2=%b%b required no overlap",
                 $time, s1_0, s2_0, s1_1, s2_1);
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    en0 = 1'b0; sync0 = 1'b0; en1 = 1'b0; sync1 = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({s1_0, s2_0, busy_0, count_0, wrap_0} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset0 got %b required 0", {s1_0, s2_0, busy_0, count_0, wrap_0});
    end
    n_vec++;
    if ({s1_1, s2_1, busy_1, count_1, wrap_1} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset1 got %b required 0", {s1_1, s2_1, busy_1, count_1, wrap_1});
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_run();
    en0 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_vec++;
      if ({s1_0, s2_0, busy_0, count_0, wrap_0} !== mexp(m0, 1, 1)) begin
        n_fail++;
        $display("FAIL run cyc%0d got %b required %b", k, {s1_0, s2_0, busy_0, count_0, wrap_0}, mexp(m0, 1, 1));
      end
      if (k == 1 || k == 3 || k == 5) begin
        n_vec++;
        if ({s1_0, s2_0} !== ((k == 3) ? 2'b01 : 2'b10)) begin
          n_fail++;
          $display("FAIL run_strobe cyc%0d got %b required %b", k, {s1_0, s2_0}, (k == 3) ? 2'b01 : 2'b10);
        end
      end
      if (k == 5) begin
        n_vec++;
        if (count_0 !== 6'd1) begin
          n_fail++;
          $display("FAIL run_count got %0d required 1", count_0);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int   wraps;
    logic [5:0] prev;
    wraps = 0;
    prev  = count_0;
    for (int k = 0; k < 228; k++) begin
      @(negedge clk);
      n_vec++;
      if ({s1_0, s2_0, busy_0, count_0, wrap_0} !== mexp(m0, 1, 1)) begin
        n_fail++;
        $display("FAIL wrap_model cyc%0d got %b required %b", k, {s1_0, s2_0, busy_0, count_0, wrap_0}, mexp(m0, 1, 1));
      end
      if (wrap_0) begin
        wraps++;
        n_vec++;
        if (prev !== 6'd56 || count_0 !== 6'd0) begin
          n_fail++;
          $display("FAIL wrap_edge got %0d->%0d required 56->0", prev, count_0);
        end
      end
      prev = count_0;
    end
    n_vec++;
    if (wraps != 1) begin
      n_fail++;
      $display("FAIL wrap_count got %0d pulses required 1", wraps);
    end
  endtask

  task automatic test_en_drop();
    int c, pulses, k;
    k = 0;
    while (!s1_0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (!s1_0) begin
      n_fail++;
      $display("FAIL endrop_timeout got s1=%b required 1", s1_0);
    end
    c      = count_0;
    en0    = 1'b0;
    pulses = 0;
    k      = 0;
    do begin
      @(negedge clk);
      k++;
      if (s2_0) pulses++;
      n_vec++;
      if ({s1_0, s2_0, busy_0, count_0, wrap_0} !== mexp(m0, 1, 1)) begin
        n_fail++;
        $display("FAIL endrop_model got %b required %b", {s1_0, s2_0, busy_0, count_0, wrap_0}, mexp(m0, 1, 1));
      end
    end while (busy_0 && k < 20);
    n_vec++;
    if (pulses != 1 || busy_0 !== 1'b0 || count_0 !== 6'((c + 1) % 57)) begin
      n_fail++;
      $display("FAIL endrop got s2pulses=%0d busy=%b count=%0d required 1/0/%0d", pulses, busy_0, count_0, (c + 1) % 57);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if ({s1_0, s2_0} !== 2'b00) begin
        n_fail++;
        $display("FAIL endrop_idle cyc%0d got %b required 00", i, {s1_0, s2_0});
      end
    end
  endtask

  task automatic test_sync();
    int   k;
    logic saw_wrap;
    sync0 = 1'b1;
    @(negedge clk);
    sync0 = 1'b0;
    n_vec++;
    if ({s1_0, s2_0, busy_0, count_0} !== 9'd0) begin
      n_fail++;
      $display("FAIL sync_idle got %b required 0", {s1_0, s2_0, busy_0, count_0});
    end
    en0 = 1'b1;
    k   = 0;
    do begin
      @(negedge clk);
      k++;
      n_vec++;
      if ({s1_0, s2_0, busy_0, count_0, wrap_0} !== mexp(m0, 1, 1)) begin
        n_fail++;
        $display("FAIL sync_model got %b required %b", {s1_0, s2_0, busy_0, count_0, wrap_0}, mexp(m0, 1, 1));
      end
    end while (!(s1_0 && count_0 == 6'd20) && k < 200);
    n_vec++;
    if (!(s1_0 && count_0 == 6'd20)) begin
      n_fail++;
      $display("FAIL sync_timeout got count=%0d required 20", count_0);
    end
    @(negedge clk);          // G1
    sync0 = 1'b1;
    @(negedge clk);
    sync0    = 1'b0;
    saw_wrap = wrap_0;
    k        = 0;
    while (!s1_0 && k < 10) begin
      @(negedge clk);
      saw_wrap |= wrap_0;
      k++;
    end
    n_vec++;
    if (s1_0 !== 1'b1 || count_0 !== 6'd0 || saw_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL sync_step got s1=%b count=%0d wrap=%b required 1/0/0", s1_0, count_0, saw_wrap);
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if (s1_0 !== 1'b1 || count_0 !== 6'd1) begin
      n_fail++;
      $display("FAIL sync_next got s1=%b count=%0d required 1/1", s1_0, count_0);
    end
  endtask

  task automatic test_wide();
    int pos;
    en1 = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      pos = (k - 1) % 10;
      n_vec++;
      if ({s1_1, s2_1} !== {pos < 3, pos >= 5 && pos < 8}) begin
        n_fail++;
        $display("FAIL wide cyc%0d got %b required %b", k, {s1_1, s2_1}, {pos < 3, pos >= 5 && pos < 8});
      end
      if (k == 11) begin
        n_vec++;
        if (count_1 !== 3'd1) begin
          n_fail++;
          $display("FAIL wide_count got %0d required 1", count_1);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int k;
    k = 0;
    while (!s2_0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (!s2_0) begin
      n_fail++;
      $display("FAIL areset_timeout got s2=%b required 1", s2_0);
    end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({s1_0, s2_0, busy_0, count_0} !== 9'd0) begin
      n_fail++;
      $display("FAIL areset got %b required 0", {s1_0, s2_0, busy_0, count_0});
    end
    @(negedge clk);
    reset_n = 1'b1;
    en0     = 1'b1;
    @(negedge clk);
    n_vec++;
    if (s1_0 !== 1'b1 || count_0 !== 6'd0) begin
      n_fail++;
      $display("FAIL areset_restart got s1=%b count=%0d required 1/0", s1_0, count_0);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      en0   = ($urandom_range(3) != 0);
      en1   = ($urandom_range(3) != 0);
      sync0 = ($urandom_range(15) == 0);
      sync1 = ($urandom_range(15) == 0);
      @(negedge clk);
      n_vec++;
      if ({s1_0, s2_0, busy_0, count_0, wrap_0} !== mexp(m0, 1, 1)) begin
        n_fail++;
        $display("FAIL rand0 cyc%0d got %b required %b", k, {s1_0, s2_0, busy_0, count_0, wrap_0}, mexp(m0, 1, 1));
      end
      n_vec++;
      if ({s1_1, s2_1, busy_1, 3'b000, count_1, wrap_1} !== mexp(m1, 3, 2)) begin
        n_fail++;
        $display("FAIL rand1 cyc%0d got %b required %b", k, {s1_1, s2_1, busy_1, 3'b000, count_1, wrap_1}, mexp(m1, 3, 2));
      end
    end
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    test_reset();
    test_run();
    test_wrap();
    test_en_drop();
    test_sync();
    test_wide();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
